// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the register file with pending-write scoreboard.
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int ZERO_ADDR  = 0;

  // Number of registers addressed by an addr_w-bit address.
  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/regfile_pending_tracker.sv
// Per-register pending bits, outstanding-reservation count and busy lookup.
module regfile_pending_tracker
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  input  logic              byp_clr1,
  input  logic              byp_clr2,
  output logic              busy1,
  output logic              busy2,
  output logic [ADDR_W:0]   pend_cnt
);

  localparam int DEPTH = depth_of(ADDR_W);
  localparam logic [ADDR_W-1:0] ZA = ADDR_W'(ZERO_ADDR);

  logic [DEPTH-1:0] pend_q;
  logic [DEPTH-1:0] pend_d;
  logic             set_ok;
  logic             cnt_inc;
  logic             cnt_dec;

  // A reservation on the hardwired zero register never takes effect.
  assign set_ok = set_en && !(ZERO_REG && set_addr == ZA);

  // Next pending vector: a new reservation supersedes a same-cycle release.
  always_comb begin
    pend_d = pend_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (clr_en && clr_addr == ADDR_W'(i))
        pend_d[i] = 1'b0;
      if (set_ok && set_addr == ADDR_W'(i))
        pend_d[i] = 1'b1;
    end
  end

  // Count only real transitions so the counter tracks the popcount exactly.
  always_comb begin
    cnt_inc = set_ok && !pend_q[set_addr];
    cnt_dec = clr_en && pend_q[clr_addr] && !(set_ok && set_addr == clr_addr);
  end

  // Pending bits and counter, cleared by reset regardless of other requests.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q   <= '0;
      pend_cnt <= '0;
    end else begin
      pend_q <= pend_d;
      if (cnt_inc && !cnt_dec)
        pend_cnt <= pend_cnt + 1'b1;
      else if (cnt_dec && !cnt_inc)
        pend_cnt <= pend_cnt - 1'b1;
    end
  end

  // Busy lookup; a same-cycle forwarded write releases the port early.
  always_comb begin
    busy1 = pend_q[rd_addr1] && !byp_clr1 && !(ZERO_REG && rd_addr1 == ZA);
    busy2 = pend_q[rd_addr2] && !byp_clr2 && !(ZERO_REG && rd_addr2 == ZA);
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Two-read/one-write register file with optional zero register, write bypass
// and a pending-write scoreboard that stalls issue on unresolved sources.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [ADDR_W-1:0] Adr1,
  input  logic [ADDR_W-1:0] Adr2,
  output logic [DATA_W-1:0] Dout1,
  output logic [DATA_W-1:0] Dout2,
  input  logic [ADDR_W-1:0] Awr,
  input  logic [DATA_W-1:0] Din,
  input  logic              WrEn,
  input  logic [ADDR_W-1:0] Ares,
  input  logic              ResEn,
  output logic              Busy1,
  output logic              Busy2,
  output logic              Stall,
  output logic [ADDR_W:0]   PendCnt
);

  localparam int DEPTH = depth_of(ADDR_W);
  localparam logic [ADDR_W-1:0] ZA = ADDR_W'(ZERO_ADDR);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_ok;
  logic              byp1;
  logic              byp2;
  logic              zero1;
  logic              zero2;

  assign wr_ok = WrEn && !(ZERO_REG && Awr == ZA);
  assign zero1 = ZERO_REG && Adr1 == ZA;
  assign zero2 = ZERO_REG && Adr2 == ZA;

  // Forwarding only applies to writes that will actually land.
  always_comb begin
    byp1 = BYPASS && wr_ok && Adr1 == Awr;
    byp2 = BYPASS && wr_ok && Adr2 == Awr;
  end

  // Storage array; reset clears every entry.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (wr_ok) begin
      mem[Awr] <= Din;
    end
  end

  // Read muxes with zero-register masking taking precedence over bypass.
  always_comb begin
    if (zero1)
      Dout1 = '0;
    else if (byp1)
      Dout1 = Din;
    else
      Dout1 = mem[Adr1];
    if (zero2)
      Dout2 = '0;
    else if (byp2)
      Dout2 = Din;
    else
      Dout2 = mem[Adr2];
  end

  regfile_pending_tracker #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_tracker (
    .clk      (Clk),
    .rst      (Rst),
    .set_en   (ResEn),
    .set_addr (Ares),
    .clr_en   (WrEn),
    .clr_addr (Awr),
    .rd_addr1 (Adr1),
    .rd_addr2 (Adr2),
    .byp_clr1 (byp1),
    .byp_clr2 (byp2),
    .busy1    (Busy1),
    .busy2    (Busy2),
    .pend_cnt (PendCnt)
  );

  assign Stall = Busy1 | Busy2;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench: one bypassing instance and one non-bypassing instance
// driven from the same stimulus.
module tb_regfile_scoreboard;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [4:0]  Adr1, Adr2, Awr, Ares;
  logic [31:0] Din;
  logic        WrEn, ResEn;

  logic [31:0] dout1_b, dout2_b, dout1_n, dout2_n;
  logic        busy1_b, busy2_b, stall_b, busy1_n, busy2_n, stall_n;
  logic [5:0]  pcnt_b, pcnt_n;

  int nerr = 0;
  int nchk = 0;

  always #5 Clk = ~Clk;

  regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut (
    .Clk(Clk), .Rst(Rst), .Adr1(Adr1), .Adr2(Adr2), .Dout1(dout1_b), .Dout2(dout2_b),
    .Awr(Awr), .Din(Din), .WrEn(WrEn), .Ares(Ares), .ResEn(ResEn),
    .Busy1(busy1_b), .Busy2(busy2_b), .Stall(stall_b), .PendCnt(pcnt_b));

  regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_nb (
    .Clk(Clk), .Rst(Rst), .Adr1(Adr1), .Adr2(Adr2), .Dout1(dout1_n), .Dout2(dout2_n),
    .Awr(Awr), .Din(Din), .WrEn(WrEn), .Ares(Ares), .ResEn(ResEn),
    .Busy1(busy1_n), .Busy2(busy2_n), .Stall(stall_n), .PendCnt(pcnt_n));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Rst = 1'b1; Adr1 = '0; Adr2 = '0; Awr = '0; Ares = '0;
    Din = '0; WrEn = 1'b0; ResEn = 1'b0;
    tick(); tick();
    Rst = 1'b0;
    #1;
    chk("rst_pcnt_b", 64'(pcnt_b), 64'd0);
    chk("rst_stall_b", 64'(stall_b), 64'd0);

    // Reset wipes stored data
    WrEn = 1'b1; Awr = 5'd1; Din = 32'h2232;
    tick();
    WrEn = 1'b0; Adr1 = 5'd1;
    #1;
    chk("r1_written", 64'(dout1_n), 64'h2232);
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    #1;
    chk("rst_dout1_b", 64'(dout1_b), 64'd0);
    chk("rst_dout1_n", 64'(dout1_n), 64'd0);
    chk("rst_pcnt_n", 64'(pcnt_n), 64'd0);
    chk("rst_stall_n", 64'(stall_n), 64'd0);

    // Write with and without bypass
    Adr1 = 5'd2; WrEn = 1'b1; Awr = 5'd2; Din = 32'hDEAD_BEEF;
    #1;
    chk("byp_same_cycle", 64'(dout1_b), 64'hDEAD_BEEF);
    chk("nobyp_old_value", 64'(dout1_n), 64'd0);
    tick();
    WrEn = 1'b0;
    #1;
    chk("byp_after_edge", 64'(dout1_b), 64'hDEAD_BEEF);
    chk("nobyp_after_edge", 64'(dout1_n), 64'hDEAD_BEEF);

    // Zero register ignores writes, bypass and reservations
    Adr1 = 5'd0; WrEn = 1'b1; Awr = 5'd0; Din = 32'h1234; ResEn = 1'b1; Ares = 5'd0;
    #1;
    chk("zero_byp_masked", 64'(dout1_b), 64'd0);
    tick();
    WrEn = 1'b0; ResEn = 1'b0;
    #1;
    chk("zero_dout1", 64'(dout1_b), 64'd0);
    chk("zero_busy1", 64'(busy1_b), 64'd0);
    chk("zero_pcnt", 64'(pcnt_b), 64'd0);

    // Scoreboard reserve and release
    Adr2 = 5'd4; ResEn = 1'b1; Ares = 5'd4;
    #1;
    chk("res_no_forward", 64'(busy2_b), 64'd0);
    tick();
    Ares = 5'd5;
    #1;
    chk("res1_pcnt", 64'(pcnt_b), 64'd1);
    chk("res1_busy2", 64'(busy2_b), 64'd1);
    chk("res1_stall", 64'(stall_b), 64'd1);
    tick();
    ResEn = 1'b0;
    #1;
    chk("res2_pcnt", 64'(pcnt_b), 64'd2);
    WrEn = 1'b1; Awr = 5'd4; Din = 32'h44;
    #1;
    chk("rel_busy2_byp", 64'(busy2_b), 64'd0);
    chk("rel_stall_byp", 64'(stall_b), 64'd0);
    chk("rel_dout2_byp", 64'(dout2_b), 64'h44);
    chk("rel_busy2_nobyp", 64'(busy2_n), 64'd1);
    tick();
    WrEn = 1'b0;
    #1;
    chk("rel_pcnt_b", 64'(pcnt_b), 64'd1);
    chk("rel_pcnt_n", 64'(pcnt_n), 64'd1);
    chk("rel_busy2_nobyp_after", 64'(busy2_n), 64'd0);

    // Release r5 while reserving r6: net zero
    Adr1 = 5'd5;
    #1;
    chk("r5_busy1", 64'(busy1_b), 64'd1);
    WrEn = 1'b1; Awr = 5'd5; Din = 32'h55; ResEn = 1'b1; Ares = 5'd6;
    tick();
    WrEn = 1'b0; ResEn = 1'b0;
    #1;
    chk("net0_pcnt", 64'(pcnt_b), 64'd1);
    chk("net0_r5_free", 64'(busy1_n), 64'd0);

    // Same-address reserve and write: reservation wins, data lands
    Adr1 = 5'd6; WrEn = 1'b1; Awr = 5'd6; Din = 32'h66; ResEn = 1'b1; Ares = 5'd6;
    #1;
    chk("same_byp_dout", 64'(dout1_b), 64'h66);
    tick();
    WrEn = 1'b0; ResEn = 1'b0;
    #1;
    chk("same_busy_b", 64'(busy1_b), 64'd1);
    chk("same_busy_n", 64'(busy1_n), 64'd1);
    chk("same_data", 64'(dout1_n), 64'h66);
    chk("same_pcnt", 64'(pcnt_b), 64'd1);

    // Re-reserve pending r6 and write non-pending r7: count unchanged
    WrEn = 1'b1; Awr = 5'd7; Din = 32'h77; ResEn = 1'b1; Ares = 5'd6;
    tick();
    WrEn = 1'b0; ResEn = 1'b0;
    #1;
    chk("noop_pcnt", 64'(pcnt_b), 64'd1);
    WrEn = 1'b1; Awr = 5'd6; Din = 32'h60;
    tick();
    WrEn = 1'b0;
    #1;
    chk("r6_clear_pcnt", 64'(pcnt_b), 64'd0);

    // Fill every non-zero register, then drain
    ResEn = 1'b1;
    for (int i = 1; i < 32; i++) begin
      Ares = 5'(i);
      tick();
    end
    ResEn = 1'b0;
    Adr1 = 5'd31; Adr2 = 5'd0;
    #1;
    chk("fill_pcnt_b", 64'(pcnt_b), 64'd31);
    chk("fill_pcnt_n", 64'(pcnt_n), 64'd31);
    chk("fill_busy31", 64'(busy1_b), 64'd1);
    chk("fill_busy_r0", 64'(busy2_b), 64'd0);
    WrEn = 1'b1;
    for (int i = 1; i < 32; i++) begin
      Awr = 5'(i);
      Din = 32'(i) + 32'h100;
      tick();
    end
    WrEn = 1'b0;
    Adr1 = 5'd17;
    #1;
    chk("drain_pcnt_b", 64'(pcnt_b), 64'd0);
    chk("drain_pcnt_n", 64'(pcnt_n), 64'd0);
    chk("drain_r17", 64'(dout1_n), 64'h111);

    // Reset with reservations outstanding and requests asserted
    ResEn = 1'b1;
    Ares = 5'd3;  tick();
    Ares = 5'd9;  tick();
    Ares = 5'd20; tick();
    ResEn = 1'b0;
    Adr1 = 5'd3; Adr2 = 5'd9;
    #1;
    chk("rr_pcnt", 64'(pcnt_b), 64'd3);
    chk("rr_stall", 64'(stall_n), 64'd1);
    Rst = 1'b1; ResEn = 1'b1; Ares = 5'd10; WrEn = 1'b1; Awr = 5'd11; Din = 32'hFF;
    tick();
    Rst = 1'b0; ResEn = 1'b0; WrEn = 1'b0;
    #1;
    chk("rr_rst_pcnt_b", 64'(pcnt_b), 64'd0);
    chk("rr_rst_pcnt_n", 64'(pcnt_n), 64'd0);
    chk("rr_rst_busy1", 64'(busy1_b), 64'd0);
    chk("rr_rst_busy2", 64'(busy2_n), 64'd0);
    chk("rr_rst_stall", 64'(stall_b), 64'd0);
    chk("rr_rst_dout1", 64'(dout1_n), 64'd0);
    Adr1 = 5'd11; Adr2 = 5'd10;
    #1;
    chk("rr_rst_wr_dropped", 64'(dout1_n), 64'd0);
    chk("rr_rst_res_dropped", 64'(busy2_n), 64'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
